// File: rtl/d_ip_m_pcrm_mctrl.sv
// Per-domain power/clock/reset sequencing controller: NUM_DOM independent FSMs.
// Define D_IP_M_PCRM_MCTRL_TMO_EN to build the per-domain ack-timeout counters and sticky errors.
module d_ip_m_pcrm_mctrl #(
    parameter int NUM_DOM = 4,
    parameter int TMO_W   = 8
) (
    input  logic                   clk,
    input  logic                   sync_rst_b,
    input  logic [TMO_W-1:0]       tmo_cyc,
    input  logic [NUM_DOM-1:0]     vdd_po_rst_b,
    input  logic [NUM_DOM-1:0]     clk_ack,
    input  logic [NUM_DOM-1:0]     clk_gting_ack,
    input  logic [NUM_DOM-1:0]     pwr_gting_ack,
    input  logic [NUM_DOM-1:0]     err_clr,
    output logic [NUM_DOM-1:0]     vdd_iso_en_b,
    output logic [NUM_DOM-1:0]     clk_gate_en_b,
    output logic [NUM_DOM-1:0]     func_rst_b,
    output logic [3*NUM_DOM-1:0]   dom_state,
    output logic [NUM_DOM-1:0]     tmo_err,
    output logic                   all_pwr_gtd
);

    typedef enum logic [2:0] {
        ST_RST         = 3'd0,
        ST_RUN         = 3'd1,
        ST_CLK_GTING   = 3'd2,
        ST_CLK_GTD     = 3'd3,
        ST_CLK_UNGTING = 3'd4,
        ST_PWR_GTING   = 3'd5,
        ST_PWR_GTD     = 3'd6,
        ST_PWR_UNGTING = 3'd7
    } state_t;

    function automatic state_t next_st(input state_t s, input logic ca, input logic cga,
                                       input logic pga, input logic vpr);
        state_t n;
        n = s;
        case (s)
            ST_RST:         if (ca)   n = ST_RUN;
            ST_RUN:         if (!ca)  n = ST_CLK_GTING;
            ST_CLK_GTING:   if (cga)  n = ST_CLK_GTD;
            // Losing vdd takes precedence over a returning clock.
            ST_CLK_GTD:     if (!vpr) n = ST_PWR_GTING;
                            else if (ca) n = ST_CLK_UNGTING;
            ST_CLK_UNGTING: if (!cga) n = ST_RUN;
            ST_PWR_GTING:   if (pga)  n = ST_PWR_GTD;
            ST_PWR_GTD:     if (vpr)  n = ST_PWR_UNGTING;
            ST_PWR_UNGTING: if (!pga) n = ST_CLK_GTD;
            default:        n = ST_RST;
        endcase
        return n;
    endfunction

    logic [NUM_DOM-1:0] pwr_gtd;

    for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
        state_t st;
        state_t st_nxt;

        assign st_nxt = next_st(st, clk_ack[i], clk_gting_ack[i], pwr_gting_ack[i],
                                vdd_po_rst_b[i]);

        always_ff @(posedge clk or negedge sync_rst_b) begin
            if (!sync_rst_b) st <= ST_RST;
            else             st <= st_nxt;
        end

        assign dom_state[3*i +: 3] = st;
        assign vdd_iso_en_b[i]  = !(st inside {ST_RST, ST_PWR_GTING, ST_PWR_GTD});
        assign clk_gate_en_b[i] = !(st inside {ST_RST, ST_CLK_GTING, ST_CLK_GTD,
                                               ST_PWR_GTING, ST_PWR_GTD, ST_PWR_UNGTING});
        assign func_rst_b[i]    = (st != ST_RST);
        assign pwr_gtd[i]       = (st == ST_PWR_GTD);

`ifdef D_IP_M_PCRM_MCTRL_TMO_EN
        logic             in_trans;
        logic             tmo_hit;
        logic [TMO_W-1:0] cnt;
        logic [TMO_W-1:0] cnt_nxt;
        logic             err;

        assign in_trans = st inside {ST_CLK_GTING, ST_CLK_UNGTING, ST_PWR_GTING, ST_PWR_UNGTING};

        always_comb begin
            cnt_nxt = '0;
            if (in_trans && (st_nxt == st))
                cnt_nxt = (&cnt) ? cnt : cnt + TMO_W'(1);
        end

        // Error becomes visible in the same cycle the count reaches the limit.
        assign tmo_hit = in_trans && (st_nxt == st) && (tmo_cyc != '0) && (cnt_nxt == tmo_cyc);

        always_ff @(posedge clk or negedge sync_rst_b) begin
            if (!sync_rst_b) begin
                cnt <= '0;
                err <= 1'b0;
            end else begin
                cnt <= cnt_nxt;
                if (tmo_hit)         err <= 1'b1;
                else if (err_clr[i]) err <= 1'b0;
            end
        end

        assign tmo_err[i] = err;
`else
        assign tmo_err[i] = 1'b0;
`endif
    end

`ifndef D_IP_M_PCRM_MCTRL_TMO_EN
    logic unused_tmo;
    assign unused_tmo = ^{tmo_cyc, err_clr};
`endif

    assign all_pwr_gtd = &pwr_gtd;

endmodule
